// File: rtl/sha256_seq_pkg.sv
// Shared widths, state codes and helpers for the SHA-256 work sequencer.
// Imported by the interface, the FIFO and the sequencer top.
package sha256_seq_pkg;

    localparam int MIDSTATE_W = 256;
    localparam int DATA2_W    = 96;
    localparam int NONCE_W    = 32;
    localparam int DROP_W     = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_ARM   = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;

    typedef logic [2:0] seq_state_t;

    function automatic logic [DROP_W-1:0] sat_inc(
        input logic [DROP_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sha256_work_sequencer_if.sv
// Host-side bundle: job offer handshake and golden-nonce drain handshake.
// master = host/comm logic, slave = sequencer.
interface sha256_work_sequencer_if
    import sha256_seq_pkg::*;
();

    logic                  work_valid;
    logic                  work_ready;
    logic [MIDSTATE_W-1:0] work_midstate;
    logic [DATA2_W-1:0]    work_data2;
    logic                  nonce_valid;
    logic [NONCE_W-1:0]    nonce_data;
    logic                  nonce_ready;

    modport master (
        output work_valid,
        output work_midstate,
        output work_data2,
        output nonce_ready,
        input  work_ready,
        input  nonce_valid,
        input  nonce_data
    );

    modport slave (
        input  work_valid,
        input  work_midstate,
        input  work_data2,
        input  nonce_ready,
        output work_ready,
        output nonce_valid,
        output nonce_data
    );

endinterface

// File: rtl/sha256_work_sequencer_fifo.sv
// First-word-fall-through golden-nonce FIFO. A push while full is
// still accepted when a pop frees the head slot in the same cycle.
module nonce_fifo
    import sha256_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [NONCE_W-1:0] i_push_data,
    input  logic               i_pop,
    output logic [NONCE_W-1:0] o_head,
    output logic               o_full,
    output logic               o_empty
);

    logic [NONCE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [AW:0]        r_count;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_head  = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sha256_work_sequencer.sv
// Drives one sha256 core through a job: latch, settle, start, arm, run.
// Golden nonces from the core are queued for the comm side.
module sha256_work_sequencer
    import sha256_seq_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int FIFO_AW       = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int ARM_TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    sha256_work_sequencer_if.slave wk,
    input  logic                   abort,
    output logic [MIDSTATE_W-1:0]  core_midstate,
    output logic [DATA2_W-1:0]     core_data2,
    output logic                   core_nonce_start,
    output logic                   core_start,
    input  logic                   core_busy,
    input  logic                   core_ticket,
    input  logic [NONCE_W-1:0]     core_golden_nonce,
    output logic                   work_done,
    output logic                   arm_error,
    output logic [DROP_W-1:0]      drop_count
);

    seq_state_t            r_state;
    logic [7:0]            r_settle_cnt;
    logic [15:0]           r_arm_cnt;
    logic [MIDSTATE_W-1:0] r_midstate;
    logic [DATA2_W-1:0]    r_data2;
    logic                  r_core_start;
    logic                  r_nonce_start;
    logic                  r_work_done;
    logic                  r_arm_error;
    logic [DROP_W-1:0]     r_drop_count;

    logic w_accept;
    logic w_abort;
    logic w_push;
    logic w_pop;
    logic w_drop;
    logic w_full;
    logic w_empty;

    assign wk.work_ready = (r_state == S_IDLE) & ~rst;
    assign w_accept      = wk.work_valid & wk.work_ready;
    assign w_abort       = abort & (r_state != S_IDLE);

    // Tickets only count once the core has been started for this job.
    assign w_push = core_ticket &
                    ((r_state == S_ARM) | (r_state == S_RUN));
    assign w_pop  = ~w_empty & wk.nonce_ready;
    assign w_drop = w_push & w_full & ~w_pop;

    assign wk.nonce_valid = ~w_empty;

    assign core_midstate    = r_midstate;
    assign core_data2       = r_data2;
    assign core_start       = r_core_start;
    assign core_nonce_start = r_nonce_start;
    assign work_done        = r_work_done;
    assign arm_error        = r_arm_error;
    assign drop_count       = r_drop_count;

    nonce_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (core_golden_nonce),
        .i_pop       (w_pop),
        .o_head      (wk.nonce_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_settle_cnt  <= '0;
            r_arm_cnt     <= '0;
            r_midstate    <= '0;
            r_data2       <= '0;
            r_core_start  <= 1'b0;
            r_nonce_start <= 1'b0;
            r_work_done   <= 1'b0;
            r_arm_error   <= 1'b0;
            r_drop_count  <= '0;
        end else begin
            r_core_start  <= 1'b0;
            r_nonce_start <= 1'b0;
            r_work_done   <= 1'b0;
            r_arm_error   <= 1'b0;
            if (w_drop) begin
                r_drop_count <= sat_inc(r_drop_count);
            end
            // Abort wins over every transition and suppresses new strobes.
            if (w_abort) begin
                r_state <= S_IDLE;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_midstate   <= wk.work_midstate;
                            r_data2      <= wk.work_data2;
                            r_settle_cnt <= '0;
                            r_state      <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (r_settle_cnt == 8'(SETTLE_CYCLES - 1)) begin
                            r_core_start  <= 1'b1;
                            r_nonce_start <= 1'b1;
                            r_state       <= S_START;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 1'b1;
                        end
                    end
                    S_START: begin
                        r_arm_cnt <= '0;
                        r_state   <= S_ARM;
                    end
                    S_ARM: begin
                        if (core_busy) begin
                            r_state <= S_RUN;
                        end else if (r_arm_cnt == 16'(ARM_TIMEOUT - 1)) begin
                            r_arm_error <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_arm_cnt <= r_arm_cnt + 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (!core_busy) begin
                            r_work_done <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha256_work_sequencer.sv
// Directed bench for sha256_work_sequencer: job flow, arm timeout,
// nonce FIFO ordering/overflow, abort and mid-run reset.
module tb_sha256_work_sequencer;
    import sha256_seq_pkg::*;

    logic                  clk;
    logic                  rst;
    logic                  abort;
    logic [MIDSTATE_W-1:0] core_midstate;
    logic [DATA2_W-1:0]    core_data2;
    logic                  core_nonce_start;
    logic                  core_start;
    logic                  core_busy;
    logic                  core_ticket;
    logic [NONCE_W-1:0]    core_golden_nonce;
    logic                  work_done;
    logic                  arm_error;
    logic [DROP_W-1:0]     drop_count;

    int n_checks = 0;
    int n_pass   = 0;

    sha256_work_sequencer_if wk ();

    sha256_work_sequencer #(
        .FIFO_DEPTH    (4),
        .FIFO_AW       (2),
        .SETTLE_CYCLES (2),
        .ARM_TIMEOUT   (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .wk                (wk),
        .abort             (abort),
        .core_midstate     (core_midstate),
        .core_data2        (core_data2),
        .core_nonce_start  (core_nonce_start),
        .core_start        (core_start),
        .core_busy         (core_busy),
        .core_ticket       (core_ticket),
        .core_golden_nonce (core_golden_nonce),
        .work_done         (work_done),
        .arm_error         (arm_error),
        .drop_count        (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a job, then walk to the first ARM cycle (accept edge + 3).
    task automatic run_to_arm(input logic [MIDSTATE_W-1:0] ms,
                              input logic [DATA2_W-1:0] d2);
        wk.work_valid    = 1'b1;
        wk.work_midstate = ms;
        wk.work_data2    = d2;
        tick();
        wk.work_valid = 1'b0;
        tick();
        tick();
        chk("start_pulse", core_start, 1);
        tick();
    endtask

    logic [MIDSTATE_W-1:0] ms1;
    logic [MIDSTATE_W-1:0] ms2;
    logic [NONCE_W-1:0]    drain_exp [4];
    int                    acc;

    initial begin
        rst               = 1'b1;
        abort             = 1'b0;
        core_busy         = 1'b0;
        core_ticket       = 1'b0;
        core_golden_nonce = '0;
        wk.work_valid     = 1'b0;
        wk.work_midstate  = '0;
        wk.work_data2     = '0;
        wk.nonce_ready    = 1'b0;
        ms1               = {64{4'h1}};
        ms2               = {8{32'hC0FFEE01}};
        drain_exp         = '{32'd2, 32'd3, 32'd4, 32'd7};

        tick();
        tick();
        chk("rst_ready", wk.work_ready, 0);
        chk("rst_start", core_start, 0);
        chk("rst_nvalid", wk.nonce_valid, 0);
        chk("rst_ndata", wk.nonce_data, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_mid", core_midstate, 0);
        rst = 1'b0;
        #1;
        chk("idle_ready", wk.work_ready, 1);

        // Normal job: accept, settle, start, busy for 100 cycles, done.
        wk.work_valid    = 1'b1;
        wk.work_midstate = ms1;
        wk.work_data2    = 96'hABC;
        tick();
        wk.work_valid = 1'b0;
        chk("acc_mid", core_midstate, ms1);
        chk("acc_d2", core_data2, 96'hABC);
        chk("acc_ready", wk.work_ready, 0);
        chk("acc_start0", core_start, 0);
        tick();
        chk("ld_start0", core_start, 0);
        tick();
        chk("st_start", core_start, 1);
        chk("st_nstart", core_nonce_start, 1);
        tick();
        chk("arm_start0", core_start, 0);
        core_busy = 1'b1;
        acc = 0;
        repeat (100) begin
            tick();
            acc += int'(work_done);
        end
        chk("run_no_done", acc, 0);
        core_busy = 1'b0;
        tick();
        chk("done_pulse", work_done, 1);
        chk("done_ready", wk.work_ready, 1);
        tick();
        chk("done_clear", work_done, 0);
        chk("mid_hold", core_midstate, ms1);

        // Arm timeout: core never goes busy.
        run_to_arm(ms2, 96'h123);
        acc = 0;
        repeat (15) begin
            tick();
            acc += int'(arm_error);
        end
        chk("arm_early", acc, 0);
        tick();
        chk("arm_err", arm_error, 1);
        chk("arm_ready", wk.work_ready, 1);
        chk("arm_nodone", work_done, 0);
        tick();
        chk("arm_clear", arm_error, 0);

        // Three tickets drained immediately.
        run_to_arm(ms1, 96'h1);
        core_busy      = 1'b1;
        tick();
        wk.nonce_ready = 1'b1;
        core_ticket    = 1'b1;
        core_golden_nonce = 32'h10;
        tick();
        chk("n10_v", wk.nonce_valid, 1);
        chk("n10", wk.nonce_data, 32'h10);
        core_golden_nonce = 32'h20;
        tick();
        chk("n20", wk.nonce_data, 32'h20);
        core_golden_nonce = 32'h30;
        tick();
        chk("n30", wk.nonce_data, 32'h30);
        core_ticket = 1'b0;
        tick();
        chk("n_empty", wk.nonce_valid, 0);

        // Overflow: six tickets into a 4-deep FIFO.
        wk.nonce_ready = 1'b0;
        core_ticket    = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            core_golden_nonce = 32'(i);
            tick();
        end
        core_ticket = 1'b0;
        chk("ovf_drop", drop_count, 2);
        chk("ovf_head", wk.nonce_data, 1);
        core_ticket       = 1'b1;
        core_golden_nonce = 32'd7;
        wk.nonce_ready    = 1'b1;
        tick();
        core_ticket    = 1'b0;
        wk.nonce_ready = 1'b0;
        chk("fullpop_drop", drop_count, 2);
        chk("fullpop_head", wk.nonce_data, 2);
        wk.nonce_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain", wk.nonce_data, drain_exp[i]);
            tick();
        end
        chk("drain_empty", wk.nonce_valid, 0);
        wk.nonce_ready = 1'b0;

        // Abort in RUN with a same-cycle ticket.
        abort             = 1'b1;
        core_ticket       = 1'b1;
        core_golden_nonce = 32'hDEAD;
        tick();
        abort       = 1'b0;
        core_ticket = 1'b0;
        chk("ab_ready", wk.work_ready, 1);
        chk("ab_nv", wk.nonce_valid, 1);
        chk("ab_dead", wk.nonce_data, 32'hDEAD);
        chk("ab_nodone", work_done, 0);
        core_busy = 1'b0;
        tick();
        chk("ab_nodone2", work_done, 0);
        chk("ab_mid", core_midstate, ms1);

        // New job after abort, then reset mid-run with two queued.
        run_to_arm(ms2, 96'h55);
        chk("new_mid", core_midstate, ms2);
        core_busy = 1'b1;
        tick();
        core_ticket       = 1'b1;
        core_golden_nonce = 32'hBEEF;
        tick();
        core_ticket = 1'b0;
        chk("pre_rst_head", wk.nonce_data, 32'hDEAD);
        rst = 1'b1;
        tick();
        chk("mr_ready", wk.work_ready, 0);
        chk("mr_nv", wk.nonce_valid, 0);
        chk("mr_nd", wk.nonce_data, 0);
        chk("mr_drop", drop_count, 0);
        chk("mr_mid", core_midstate, 0);
        chk("mr_d2", core_data2, 0);
        chk("mr_start", core_start, 0);
        chk("mr_done", work_done, 0);
        chk("mr_err", arm_error, 0);
        rst       = 1'b0;
        core_busy = 1'b0;
        tick();
        chk("mr_idle", wk.work_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
